adau1761_i2s_tx: RTL and testbench
==================================

# adau1761_i2s_tx

Stereo I2S transmitter driving the ADAU1761 DAC serial input once the codec has been brought up over SPI. It accepts left/right sample pairs over a valid/ready interface, holds one pair in a buffer, and serialises it as I2S. It generates BCLK/LRCLK as master from the system clock and reports underruns when no sample pair is ready at a frame boundary.

## Interface
- DATA_WIDTH, 24: sample width in bits; must be ≤ SLOT_WIDTH-1.
- SLOT_WIDTH, 32: BCLK periods per channel slot.
- BCLK_DIV, 4: clk cycles per BCLK half-period; must be ≥ 2.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run the serial interface; typically tied to configuration-done.
- s_left  in  DATA_WIDTH  left sample, two's complement.
- s_right  in  DATA_WIDTH  right sample.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  holding buffer empty; transfer when s_valid & s_ready.
- bclk  out  1  bit clock to codec.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data to codec DAC input.
- underrun  out  1  one-cycle pulse on an underrun frame.
- underrun_count  out  16  saturating underrun counter.

## Operation
- Reset values: s_ready 1, bclk 0, lrclk 1, sdata 0, underrun 0, underrun_count 0. Holding buffer is empty, bit_cnt is 2*SLOT_WIDTH-1, and div_cnt is 0.
- Holding buffer: one {left,right} entry with a full flag. s_ready equals !full and is registered.
- The buffer fills on a handshake. It empties on a frame load.
- A handshake and a frame load in the same cycle with the buffer empty:
  - The frame underruns.
  - The handshaken pair fills the buffer for the next frame.
- Divider: div_cnt counts 0..BCLK_DIV-1 while enable=1. At BCLK_DIV-1 it wraps and bclk toggles.
- On each bclk falling edge (the same clk edge where bclk goes 1→0), bit_cnt advances modulo 2*SLOT_WIDTH.
- Frame start is bit_cnt wrapping to 0. At frame start:
  - If the buffer is full, the shift registers load {left,right} and full clears.
  - Otherwise, underrun pulses, underrun_count increments (saturating at 0xFFFF), and the shift contents follow the Configuration rule.
- Outputs on each falling edge, with p = bit_cnt mod SLOT_WIDTH:
  - lrclk = (bit_cnt ≥ SLOT_WIDTH).
  - sdata = 0 for p=0.
  - sdata = channel bit DATA_WIDTH-p for p=1..DATA_WIDTH (MSB first).
  - sdata = 0 for p>DATA_WIDTH.
- States:
  - IDLE (enable=0): all counters held at their reset values, bclk 0, lrclk 1, sdata 0. The buffer still accepts one pair.
  - RUN (enable=1).
  - The transition IDLE→RUN takes effect on the first clk with enable=1.
  - Dropping enable mid-frame returns to IDLE on the next clk. The partial frame is abandoned; the buffer is not cleared.
- A reset mid-frame returns every register to its reset value immediately and discards the buffered pair.

## Timing
- BCLK period is 2*BCLK_DIV clk cycles. One frame is 2*SLOT_WIDTH BCLK periods, which is 512 clk cycles at the defaults.
- After enable rises, the first bclk rising edge occurs BCLK_DIV clks later. The first falling edge, which is frame start, occurs 2*BCLK_DIV clks after enable rises.
- lrclk and sdata change only on bclk falling edges, in the same clk cycle as bclk, so the codec samples them on the rising edge.
- The MSB appears on sdata one BCLK after the lrclk transition (standard I2S delay).
- s_ready rises one clk after a frame load and falls one clk after a handshake.
- The underrun pulse coincides with the frame-start clk edge.

## Configuration
- ADAU1761_I2S_TX_REPEAT_ON_UNDERRUN_EN:
  - Defined: an underrun frame retransmits the last loaded pair. After reset with no load, that pair is zero.
  - Undefined: an underrun frame transmits all zeros.
  - Underrun reporting is identical in both cases.

## Test plan
- Reset, then enable=1 with defaults, pair left=0xABCDEF, right=0x123456 presented before the first frame start:
  - First frame: lrclk low for 32 BCLK, then high for 32.
  - sdata: 0, then 0xABCDEF MSB-first, then 7 zeros; the right slot likewise with 0x123456.
- Back-to-back pairs with s_valid held high: one handshake per 512 clks, no underrun pulses, and s_ready low except for one clk following each frame load.
- No data presented for 3 frames: underrun pulses 3 times and underrun_count=3.
  - Macro undefined: sdata stays 0.
  - Macro defined: sdata repeats the last loaded pair.
- Handshake in the exact frame-start clk with the buffer empty: that frame underruns (count +1) and the pair is transmitted in the following frame.
- Drop enable at bit_cnt=40 and re-raise it 10 clks later: bclk stays 0 and lrclk is 1 while disabled. On restart, frame start occurs 8 clks after enable rises and the buffered pair is sent intact.
- Assert reset mid-frame: all outputs take their reset values within the same cycle, asynchronously. s_ready is 1 and underrun_count is 0 after release.

Source files
------------

// File: rtl/adau1761_i2s_tx.sv
// Stereo I2S master transmitter for the ADAU1761 DAC input; one-pair holding buffer, BCLK/LRCLK
// from clk. Define ADAU1761_I2S_TX_REPEAT_ON_UNDERRUN_EN to resend the last pair on underrun.
module adau1761_i2s_tx #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int unsigned CntW = $clog2(2 * SLOT_WIDTH);
  localparam int unsigned DivW = $clog2(BCLK_DIV);
  localparam logic [CntW-1:0] BitLast = CntW'(2 * SLOT_WIDTH - 1);
  localparam logic [CntW-1:0] SlotLen = CntW'(SLOT_WIDTH);
  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);

  logic [DivW-1:0]       div_cnt;
  logic [CntW-1:0]       bit_cnt;
  logic                  full;
  logic [DATA_WIDTH-1:0] buf_left, buf_right;
  logic [DATA_WIDTH-1:0] frame_left, frame_right;

  logic            fall, frame_start, handshake, load, full_d, slot_right, bit_out;
  logic [CntW-1:0] bit_nxt, pos;

  always_comb begin
    fall        = enable && bclk && (div_cnt == DivLast);
    bit_nxt     = (bit_cnt == BitLast) ? '0 : bit_cnt + CntW'(1);
    frame_start = fall && (bit_nxt == '0);
    slot_right  = (bit_nxt >= SlotLen);
    pos         = slot_right ? bit_nxt - SlotLen : bit_nxt;
    // Slot position p carries channel bit DATA_WIDTH-p; p=0 is the one-BCLK I2S delay.
    bit_out = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (pos == CntW'(DATA_WIDTH - i)) begin
        bit_out = slot_right ? frame_right[i] : frame_left[i];
      end
    end
    handshake = s_valid && s_ready;
    load      = frame_start && full;
    full_d    = full;
    if (load) full_d = 1'b0;
    if (handshake) full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt        <= '0;
      bit_cnt        <= BitLast;
      full           <= 1'b0;
      buf_left       <= '0;
      buf_right      <= '0;
      frame_left     <= '0;
      frame_right    <= '0;
      s_ready        <= 1'b1;
      bclk           <= 1'b0;
      lrclk          <= 1'b1;
      sdata          <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      // The buffer keeps accepting while idle; only a frame load empties it.
      if (handshake) begin
        buf_left  <= s_left;
        buf_right <= s_right;
      end
      full     <= full_d;
      s_ready  <= !full_d;
      underrun <= 1'b0;

      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= BitLast;
        bclk    <= 1'b0;
        lrclk   <= 1'b1;
        sdata   <= 1'b0;
      end else if (div_cnt == DivLast) begin
        div_cnt <= '0;
        bclk    <= !bclk;
        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk   <= slot_right;
          sdata   <= bit_out;
          if (frame_start) begin
            if (full) begin
              frame_left  <= buf_left;
              frame_right <= buf_right;
            end else begin
              underrun <= 1'b1;
              if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
`ifndef ADAU1761_I2S_TX_REPEAT_ON_UNDERRUN_EN
              frame_left  <= '0;
              frame_right <= '0;
`endif
            end
          end
        end
      end else begin
        div_cnt <= div_cnt + DivW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adau1761_i2s_tx.sv
// Directed bench for adau1761_i2s_tx: framing, back-to-back flow, underrun, enable drop and reset.
module tb_adau1761_i2s_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] s_left = '0;
  logic [23:0] s_right = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, bclk, lrclk, sdata, underrun;
  logic [15:0] underrun_count;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int ready_hi = 0;
  int ur_cnt = 0;

  adau1761_i2s_tx #(
    .DATA_WIDTH(24),
    .SLOT_WIDTH(32),
    .BCLK_DIV  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .s_left        (s_left),
    .s_right       (s_right),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    if (s_ready) ready_hi <= ready_hi + 1;
    if (underrun) ur_cnt <= ur_cnt + 1;
  end

  // Expected slot image: I2S delay bit, 24 data bits MSB first, 7 pad zeros.
  function automatic logic [31:0] slot(input logic [23:0] d);
    return {1'b0, d, 7'b0};
  endfunction

  task automatic wait_frame_start(output int waited);
    logic prev;
    prev   = lrclk;
    waited = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (prev && !lrclk) begin
        waited = i;
        return;
      end
      prev = lrclk;
    end
    tests++;
    fails++;
    $display("FAIL frame_start_timeout: none in 2000 clks, required one");
  endtask

  task automatic capture_bits(output logic [31:0] l, output logic [31:0] r, output int lr_bad);
    logic prev, got;
    l = '0;
    r = '0;
    lr_bad = 0;
    prev = bclk;
    for (int k = 0; k < 64; k++) begin
      got = 1'b0;
      for (int j = 0; j < 100 && !got; j++) begin
        @(negedge clk);
        if (!prev && bclk) got = 1'b1;
        prev = bclk;
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL bclk_timeout: no bclk rise at bit %0d", k);
        return;
      end
      if (k < 32) l = {l[30:0], sdata};
      else r = {r[30:0], sdata};
      if (lrclk !== (k >= 32)) lr_bad++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    tests++;
    if (bclk !== 1'b0) begin fails++; $display("FAIL reset_bclk: got %b want 0", bclk); end
    tests++;
    if (lrclk !== 1'b1) begin fails++; $display("FAIL reset_lrclk: got %b want 1", lrclk); end
    tests++;
    if (sdata !== 1'b0 || underrun !== 1'b0 || underrun_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_misc: sdata %b underrun %b count %0d want 0 0 0", sdata, underrun,
               underrun_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [31:0] l, r;
    int lb, first_rise, first_lr0;
    @(negedge clk);
    s_left  = 24'hABCDEF;
    s_right = 24'h123456;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    tests++;
    if (s_ready !== 1'b0) begin fails++; $display("FAIL idle_accept: s_ready %b want 0", s_ready); end
    enable = 1'b1;
    first_rise = 0;
    first_lr0  = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bclk && first_rise == 0) first_rise = i;
      if (!lrclk && first_lr0 == 0) first_lr0 = i;
    end
    tests++;
    if (first_rise != 4) begin fails++; $display("FAIL first_bclk_rise: clk %0d want 4", first_rise); end
    tests++;
    if (first_lr0 != 8) begin fails++; $display("FAIL first_frame_start: clk %0d want 8", first_lr0); end
    tests++;
    if (s_ready !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL first_load: s_ready %b underrun %b want 1 0", s_ready, underrun);
    end
    s_left  = 24'h000001;
    s_right = 24'h800000;
    s_valid = 1'b1;
    capture_bits(l, r, lb);
    tests++;
    if (l !== slot(24'hABCDEF) || r !== slot(24'h123456) || lb != 0) begin
      fails++;
      $display("FAIL first_frame_data: l %h r %h lr_bad %0d want %h %h 0", l, r, lb,
               slot(24'hABCDEF), slot(24'h123456));
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pl[4], pr[4];
    logic [31:0] l, r;
    int lb, w, hs0, rd0, ur0;
    pl = '{24'h000001, 24'h7FFFFF, 24'h5A5A5A, 24'hC0FFEE};
    pr = '{24'h800000, 24'hFFFFFF, 24'hA5A5A5, 24'h0BEEF0};
    hs0 = hs_cnt;
    rd0 = ready_hi;
    ur0 = ur_cnt;
    for (int f = 0; f < 3; f++) begin
      wait_frame_start(w);
      tests++;
      if (s_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b want 1", f, s_ready); end
      s_left  = pl[f+1];
      s_right = pr[f+1];
      capture_bits(l, r, lb);
      tests++;
      if (l !== slot(pl[f]) || r !== slot(pr[f]) || lb != 0) begin
        fails++;
        $display("FAIL b2b_data_%0d: l %h r %h lr_bad %0d want %h %h 0", f, l, r, lb,
                 slot(pl[f]), slot(pr[f]));
      end
    end
    tests++;
    if (hs_cnt - hs0 != 3 || ready_hi - rd0 != 3 || ur_cnt - ur0 != 0) begin
      fails++;
      $display("FAIL b2b_flow: handshakes %0d ready_cycles %0d underruns %0d want 3 3 0",
               hs_cnt - hs0, ready_hi - rd0, ur_cnt - ur0);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_underrun();
    logic [31:0] l, r, el, er;
    int lb, w, ur0;
`ifdef ADAU1761_I2S_TX_REPEAT_ON_UNDERRUN_EN
    el = slot(24'hC0FFEE);
    er = slot(24'h0BEEF0);
`else
    el = '0;
    er = '0;
`endif
    wait_frame_start(w);
    capture_bits(l, r, lb);
    tests++;
    if (l !== slot(24'hC0FFEE) || r !== slot(24'h0BEEF0)) begin
      fails++;
      $display("FAIL last_pair: l %h r %h want %h %h", l, r, slot(24'hC0FFEE), slot(24'h0BEEF0));
    end
    ur0 = ur_cnt;
    for (int f = 0; f < 3; f++) begin
      wait_frame_start(w);
      tests++;
      if (underrun !== 1'b1) begin fails++; $display("FAIL underrun_pulse_%0d: got %b want 1", f, underrun); end
      capture_bits(l, r, lb);
      tests++;
      if (l !== el || r !== er) begin
        fails++;
        $display("FAIL underrun_data_%0d: l %h r %h want %h %h", f, l, r, el, er);
      end
    end
    tests++;
    if (underrun_count !== 16'd3 || ur_cnt - ur0 != 3) begin
      fails++;
      $display("FAIL underrun_count: count %0d pulses %0d want 3 3", underrun_count, ur_cnt - ur0);
    end
  endtask

  task automatic test_frame_start_handshake();
    logic [31:0] l, r, el, er;
    int lb, w;
`ifdef ADAU1761_I2S_TX_REPEAT_ON_UNDERRUN_EN
    el = slot(24'hC0FFEE);
    er = slot(24'h0BEEF0);
`else
    el = '0;
    er = '0;
`endif
    // Last bclk rise was just seen; frame start is the 4th posedge from it.
    repeat (3) @(negedge clk);
    s_left  = 24'h13579B;
    s_right = 24'h2468AC;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    tests++;
    if (underrun !== 1'b1 || lrclk !== 1'b0 || s_ready !== 1'b0 || underrun_count !== 16'd4) begin
      fails++;
      $display("FAIL fs_hs_edge: underrun %b lrclk %b s_ready %b count %0d want 1 0 0 4", underrun,
               lrclk, s_ready, underrun_count);
    end
    capture_bits(l, r, lb);
    tests++;
    if (l !== el || r !== er) begin fails++; $display("FAIL fs_hs_underrun_data: l %h r %h want %h %h", l, r, el, er); end
    wait_frame_start(w);
    tests++;
    if (underrun !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL fs_hs_load: underrun %b s_ready %b want 0 1", underrun, s_ready);
    end
    s_left  = 24'h111111;
    s_right = 24'h222222;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    capture_bits(l, r, lb);
    tests++;
    if (l !== slot(24'h13579B) || r !== slot(24'h2468AC)) begin
      fails++;
      $display("FAIL fs_hs_next_frame: l %h r %h want %h %h", l, r, slot(24'h13579B), slot(24'h2468AC));
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] l, r;
    logic prev;
    int lb, w, falls, bad;
    wait_frame_start(w);
    s_left  = 24'h800001;
    s_right = 24'h7FFFFE;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    prev  = bclk;
    falls = 0;
    for (int i = 0; i < 1000 && falls < 40; i++) begin
      @(negedge clk);
      if (prev && !bclk) falls++;
      prev = bclk;
    end
    enable = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL disabled_outputs: %0d bad clks want 0", bad); end
    enable = 1'b1;
    wait_frame_start(w);
    tests++;
    if (w != 8) begin fails++; $display("FAIL restart_latency: %0d clks want 8", w); end
    tests++;
    if (underrun !== 1'b0) begin fails++; $display("FAIL restart_underrun: got %b want 0", underrun); end
    capture_bits(l, r, lb);
    tests++;
    if (l !== slot(24'h800001) || r !== slot(24'h7FFFFE) || lb != 0) begin
      fails++;
      $display("FAIL restart_data: l %h r %h lr_bad %0d want %h %h 0", l, r, lb,
               slot(24'h800001), slot(24'h7FFFFE));
    end
  endtask

  task automatic test_async_reset();
    int w;
    wait_frame_start(w);
    tests++;
    if (underrun_count !== 16'd5) begin fails++; $display("FAIL pre_reset_count: %0d want 5", underrun_count); end
    s_left  = 24'h0F0F0F;
    s_right = 24'hF0F0F0;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b1 || bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0 || underrun !== 1'b0 ||
        underrun_count !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: s_ready %b bclk %b lrclk %b sdata %b underrun %b count %0d want 1 0 1 0 0 0",
               s_ready, bclk, lrclk, sdata, underrun, underrun_count);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1 || underrun_count !== 16'd0) begin
      fails++;
      $display("FAIL post_reset: s_ready %b count %0d want 1 0", s_ready, underrun_count);
    end
    enable = 1'b1;
    wait_frame_start(w);
    tests++;
    if (w != 8 || underrun !== 1'b1 || underrun_count !== 16'd1) begin
      fails++;
      $display("FAIL buffer_discarded: latency %0d underrun %b count %0d want 8 1 1", w, underrun,
               underrun_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_underrun();
    test_frame_start_handshake();
    test_enable_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
